// File: rtl/codebook_b11_pkg.sv
// Shared constants for the B11 prefix-code decoder: codeword lengths,
// codebook table entries and the decoder FSM state encoding.
package codebook_b11_pkg;

  localparam logic [4:0] LEN_14 = 5'd14;
  localparam logic [4:0] LEN_15 = 5'd15;
  localparam logic [4:0] LEN_19 = 5'd19;
  localparam logic [4:0] LEN_20 = 5'd20;

  localparam logic [3:0] TERM = 4'hF;

  localparam logic [13:0] BASE_14 = 14'h3FF4;
  localparam int          NUM_14  = 7;

  localparam logic [14:0] BASE_15     = 15'h7FF6;
  localparam int          NUM_15      = 9;
  localparam logic [5:0]  CNT_15_BASE = 6'd8;

  localparam logic [18:0] BASE_19 = 19'h7FFF0;
  localparam int          NUM_19  = 6;

  localparam logic [19:0] BASE_20 = 20'hFFFEC;
  localparam int          NUM_20  = 20;

  localparam logic [5:0] CNT_19 [NUM_19] = '{6'd3, 6'd4, 6'd4, 6'd5, 6'd5, 6'd5};
  localparam logic [31:0] DATA_19 [NUM_19] = '{
    32'h0000001F, 32'h0000001F, 32'h0000010F,
    32'h0000001F, 32'h0000010F, 32'h0000100F
  };

  localparam logic [5:0] CNT_20 [NUM_20] = '{
    6'd2, 6'd3, 6'd3, 6'd6, 6'd6, 6'd6, 6'd6, 6'd7, 6'd7, 6'd7,
    6'd7, 6'd7, 6'd8, 6'd8, 6'd8, 6'd13, 6'd14, 6'd14, 6'd15, 6'd15
  };
  localparam logic [31:0] DATA_20 [NUM_20] = '{
    32'h0000002F, 32'h0000002F, 32'h0000020F, 32'h0000001F, 32'h0000010F,
    32'h0000100F, 32'h0001000F, 32'h0000001F, 32'h0000010F, 32'h0000100F,
    32'h0001000F, 32'h0010000F, 32'h0000001F, 32'h0000010F, 32'h0100000F,
    32'h0000002F, 32'h0000002F, 32'h0000020F, 32'h0000002F, 32'h0000200F
  };

  typedef enum logic [1:0] {
    SHIFT = 2'd0,
    HOLD  = 2'd1,
    ERR   = 2'd2
  } state_t;

endpackage

// File: rtl/codebook_b11_lut.sv
// Combinational codebook lookup: classifies a code of a given length as a
// complete codeword (match), an illegal prefix (invalid), or neither.
module codebook_b11_lut
  import codebook_b11_pkg::*;
(
  input  logic [4:0]  length,
  input  logic [19:0] code,
  output logic        match,
  output logic        invalid,
  output logic [5:0]  cnt,
  output logic [31:0] data
);

  logic [2:0] idx19;
  logic [4:0] idx20;

  // Lengths other than 14/15/19/20 are always proper prefixes of a longer code.
  always_comb begin
    match   = 1'b0;
    invalid = 1'b0;
    cnt     = '0;
    data    = '0;
    idx19   = 3'(code[18:0] - BASE_19);
    idx20   = 5'(code - BASE_20);
    case (length)
      LEN_14: begin
        if (code[13:0] < BASE_14) begin
          invalid = 1'b1;
        end else if (code[13:0] < BASE_14 + 14'(NUM_14)) begin
          match = 1'b1;
          cnt   = 6'(code[13:0] - BASE_14) + 6'd1;
          data  = {28'd0, TERM};
        end
      end
      LEN_15: begin
        if (code[14:0] >= BASE_15 && code[14:0] < BASE_15 + 15'(NUM_15)) begin
          match = 1'b1;
          cnt   = CNT_15_BASE + 6'(code[14:0] - BASE_15);
          data  = {28'd0, TERM};
        end
      end
      LEN_19: begin
        if (code[18:0] >= BASE_19 && code[18:0] < BASE_19 + 19'(NUM_19)) begin
          match = 1'b1;
          cnt   = CNT_19[idx19];
          data  = DATA_19[idx19];
        end
      end
      LEN_20: begin
        if (code >= BASE_20) begin
          match = 1'b1;
          cnt   = CNT_20[idx20];
          data  = DATA_20[idx20];
        end else begin
          invalid = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/codebook_b11_decoder.sv
// Bit-serial B11 codebook decoder: shifts codeword bits in MSB first and
// presents the decoded active prefix through a valid/ready handshake.
module codebook_b11_decoder
  import codebook_b11_pkg::*;
#(
  parameter int CODEBOOK_LENGTH_MAX = 64,
  parameter int CODEWORD_LENGTH_MAX = 20
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic                           clear_i,
  input  logic                           bit_valid_i,
  input  logic                           bit_data_i,
  output logic                           bit_ready_o,
  output logic                           ap_valid_o,
  input  logic                           ap_ready_i,
  output logic [5:0]                     ap_cnt_o,
  output logic [CODEBOOK_LENGTH_MAX-1:0] ap_data_o,
  output logic                           err_o
);

  state_t state_q, state_d;

  logic [CODEWORD_LENGTH_MAX-1:0] sr_q;
  logic [CODEWORD_LENGTH_MAX-1:0] sr_next;
  logic [4:0]                     len_q;
  logic [4:0]                     len_next;
  logic [5:0]                     cnt_q;
  logic [CODEBOOK_LENGTH_MAX-1:0] data_q;

  logic        accept;
  logic        lut_match;
  logic        lut_invalid;
  logic [5:0]  lut_cnt;
  logic [31:0] lut_data;

  assign bit_ready_o = (state_q == SHIFT);
  assign ap_valid_o  = (state_q == HOLD);
  assign err_o       = (state_q == ERR);
  assign ap_cnt_o    = cnt_q;
  assign ap_data_o   = data_q;

  // The lookup sees the register as it will be once the offered bit lands.
  assign accept   = bit_ready_o & bit_valid_i & ~clear_i;
  assign sr_next  = {sr_q[CODEWORD_LENGTH_MAX-2:0], bit_data_i};
  assign len_next = len_q + 5'd1;

  codebook_b11_lut u_lut (
    .length  (len_next),
    .code    (20'(sr_next)),
    .match   (lut_match),
    .invalid (lut_invalid),
    .cnt     (lut_cnt),
    .data    (lut_data)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= SHIFT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SHIFT: begin
        if (accept && lut_match) begin
          state_d = HOLD;
        end else if (accept && lut_invalid) begin
          state_d = ERR;
        end
      end
      HOLD:    if (ap_ready_i) state_d = SHIFT;
      ERR:     state_d = ERR;
      default: state_d = SHIFT;
    endcase
    if (clear_i) begin
      state_d = SHIFT;
    end
  end

  // Shift register is zeroed on every codeword boundary so upper bits stay clean.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sr_q   <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
      data_q <= '0;
    end else if (clear_i) begin
      sr_q   <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
      data_q <= '0;
    end else if (accept) begin
      if (lut_match) begin
        sr_q   <= '0;
        len_q  <= '0;
        cnt_q  <= lut_cnt;
        data_q <= CODEBOOK_LENGTH_MAX'(lut_data);
      end else if (lut_invalid) begin
        sr_q  <= '0;
        len_q <= '0;
      end else begin
        sr_q  <= sr_next;
        len_q <= len_next;
      end
    end else if (state_q == HOLD && ap_ready_i) begin
      cnt_q  <= '0;
      data_q <= '0;
    end
  end

endmodule

// File: tb/tb_codebook_b11_decoder.sv
// Scoreboard bench for codebook_b11_decoder: directed corner cases followed
// by a randomized codeword stream with random input gaps and backpressure.
module tb_codebook_b11_decoder;

  typedef struct {
    logic [19:0] code;
    int          len;
    logic [5:0]  cnt;
    logic [63:0] data;
  } cw_t;

  logic        clk = 1'b0;
  logic        rstN;
  logic        clear;
  logic        bitValid;
  logic        bitData;
  logic        bitReady;
  logic        apValid;
  logic        apReady;
  logic [5:0]  apCnt;
  logic [63:0] apData;
  logic        err;

  int  errors   = 0;
  int  checks   = 0;
  int  received = 0;
  bit  gapMode     = 1'b0;
  bit  readyRandom = 1'b0;
  bit  readyLevel  = 1'b1;
  cw_t book[$];
  cw_t expQ[$];

  codebook_b11_decoder #(
    .CODEBOOK_LENGTH_MAX (64),
    .CODEWORD_LENGTH_MAX (20)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rstN),
    .clear_i     (clear),
    .bit_valid_i (bitValid),
    .bit_data_i  (bitData),
    .bit_ready_o (bitReady),
    .ap_valid_o  (apValid),
    .ap_ready_i  (apReady),
    .ap_cnt_o    (apCnt),
    .ap_data_o   (apData),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  // Downstream ready: either a held level or a coin flip every cycle.
  initial apReady = 1'b1;
  always begin
    @(posedge clk);
    #2;
    apReady = readyRandom ? 1'($urandom_range(0, 1)) : readyLevel;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic cw_t mkCw(input logic [19:0] code, input int len, input int cnt, input logic [63:0] data);
    cw_t c;
    c.code = code;
    c.len  = len;
    c.cnt  = 6'(cnt);
    c.data = data;
    return c;
  endfunction

  function automatic int findIdx(input logic [19:0] code, input int len);
    for (int i = 0; i < book.size(); i++) begin
      if (book[i].code == code && book[i].len == len) return i;
    end
    return 0;
  endfunction

  // Monitor: pops the scoreboard on each accepted transfer.
  always @(negedge clk) begin
    if (rstN) begin
      if (apValid) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_output: got cnt=%0d data=%0h expected none", apCnt, apData);
        end else begin
          checkOutput("ap_cnt", 64'(apCnt), 64'(expQ[0].cnt));
          checkOutput("ap_data", apData, expQ[0].data);
          if (apReady) begin
            void'(expQ.pop_front());
            received++;
          end
        end
      end else begin
        checkOutput("idle_cnt", 64'(apCnt), 64'd0);
        checkOutput("idle_data", apData, 64'd0);
      end
    end
  end

  task automatic sendBit(input logic b);
    int n;
    if (gapMode && $urandom_range(0, 2) == 0) begin
      repeat ($urandom_range(1, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    bitValid = 1'b1;
    bitData  = b;
    n = 0;
    @(negedge clk);
    while (!bitReady && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bitReady) begin
      checks++;
      errors++;
      $display("[TB] FAIL bit_ready_timeout: got 0 expected 1 at %0t", $time);
    end
    @(posedge clk);
    #1;
    bitValid = 1'b0;
  endtask

  task automatic sendRaw(input logic [19:0] code, input int len);
    for (int i = len - 1; i >= 0; i--) sendBit(code[i]);
  endtask

  task automatic applyStimulus(input int idx);
    expQ.push_back(book[idx]);
    sendRaw(book[idx].code, book[idx].len);
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d pending expected 0", expQ.size());
      expQ.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c19[6];
    int c20[20];
    logic [63:0] d19[6];
    logic [63:0] d20[20];
    int rec0;

    c19 = '{3, 4, 4, 5, 5, 5};
    d19 = '{64'h1F, 64'h1F, 64'h10F, 64'h1F, 64'h10F, 64'h100F};
    c20 = '{2, 3, 3, 6, 6, 6, 6, 7, 7, 7, 7, 7, 8, 8, 8, 13, 14, 14, 15, 15};
    d20 = '{64'h2F, 64'h2F, 64'h20F, 64'h1F, 64'h10F, 64'h100F, 64'h1000F,
            64'h1F, 64'h10F, 64'h100F, 64'h1000F, 64'h10000F, 64'h1F, 64'h10F,
            64'h100000F, 64'h2F, 64'h2F, 64'h20F, 64'h2F, 64'h200F};
    for (int k = 0; k < 7; k++) book.push_back(mkCw(20'(32'h3FF4 + k), 14, k + 1, 64'hF));
    for (int k = 0; k < 9; k++) book.push_back(mkCw(20'(32'h7FF6 + k), 15, 8 + k, 64'hF));
    for (int k = 0; k < 6; k++) book.push_back(mkCw(20'(32'h7FFF0 + k), 19, c19[k], d19[k]));
    for (int k = 0; k < 20; k++) book.push_back(mkCw(20'(32'hFFFEC + k), 20, c20[k], d20[k]));

    rstN = 1'b0; clear = 1'b0; bitValid = 1'b0; bitData = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_valid", 64'(apValid), 64'd0);
    checkOutput("rst_cnt", 64'(apCnt), 64'd0);
    checkOutput("rst_data", apData, 64'd0);
    checkOutput("rst_err", 64'(err), 64'd0);
    @(posedge clk); #1;
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("rst_bit_ready", 64'(bitReady), 64'd1);
    @(posedge clk); #1;

    // Shortest codeword and first-cycle latency
    applyStimulus(findIdx(20'h3FF4, 14));
    @(negedge clk);
    checkOutput("latency_valid", 64'(apValid), 64'd1);
    waitDrain();

    applyStimulus(findIdx(20'hFFFFF, 20));
    waitDrain();
    applyStimulus(findIdx(20'h7FFF3, 19));
    waitDrain();

    // Backpressure: output must hold while ready is low
    readyLevel = 1'b0;
    rec0 = received;
    applyStimulus(findIdx(20'h7FF6, 15));
    repeat (10) begin
      @(negedge clk);
      checkOutput("stall_valid", 64'(apValid), 64'd1);
      checkOutput("stall_bit_ready", 64'(bitReady), 64'd0);
    end
    checkOutput("stall_pending", 64'(expQ.size()), 64'd1);
    @(posedge clk); #1;
    readyLevel = 1'b1;
    waitDrain();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("stall_single_transfer", 64'(received - rec0), 64'd1);

    // Invalid 14-bit prefix, then recovery via clear
    sendRaw(20'h3FF0, 14);
    @(negedge clk);
    checkOutput("err_set", 64'(err), 64'd1);
    checkOutput("err_bit_ready", 64'(bitReady), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("err_sticky", 64'(err), 64'd1);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    checkOutput("clear_err", 64'(err), 64'd0);
    checkOutput("clear_bit_ready", 64'(bitReady), 64'd1);
    @(posedge clk); #1;
    applyStimulus(findIdx(20'h3FFA, 14));
    waitDrain();

    // Reset in the middle of a codeword
    sendRaw(20'(20'hFFFEC >> 11), 9);
    #2;
    rstN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b1;
    @(posedge clk); #1;
    rec0 = received;
    applyStimulus(findIdx(20'hFFFEC, 20));
    waitDrain();
    repeat (5) @(posedge clk);
    #1;
    checkOutput("reset_single_output", 64'(received - rec0), 64'd1);

    // Random stream: every codeword once, then random picks
    gapMode = 1'b1;
    readyRandom = 1'b1;
    for (int i = 0; i < book.size(); i++) applyStimulus(i);
    repeat (120) applyStimulus(int'($urandom_range(0, book.size() - 1)));
    waitDrain();
    checkOutput("final_queue_empty", 64'(expQ.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
